// File: rtl/loader_pkg.sv
// Shared types for the instruction-memory loader: FSM state encoding and frame constants.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } loader_state_t;

    localparam int LEN_BYTES = 4;

endpackage

// File: rtl/instr_mem_loader.sv
// Receives a length-prefixed, checksummed byte stream and writes the payload little-endian
// into the instruction store, holding the CPU in reset until the image is verified.
module instr_mem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [7:0]            wr_data,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  err
);

    // One extra bit so a full-capacity image can be counted without wrapping.
    localparam int          CW       = ADDR_WIDTH + 1;
    localparam logic [32:0] CAPACITY = 33'(1) << ADDR_WIDTH;

    loader_state_t state, next_state;

    logic [CW-1:0] cnt;
    logic [31:0]   len_q;
    logic [7:0]    sum;

    logic          take;
    logic          len_last;
    logic          data_last;
    logic [31:0]   len_full;

    // A load_start pulse owns the cycle; a byte offered alongside it is left unconsumed.
    assign take      = in_valid & in_ready & ~load_start;
    assign len_last  = (cnt == CW'(LEN_BYTES - 1));
    assign data_last = ((32'(cnt) + 32'd1) == len_q);
    assign len_full  = {in_data, len_q[23:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (load_start) begin
            next_state = LEN;
        end else begin
            case (state)
                LEN: begin
                    if (take && len_last) begin
                        if ({1'b0, len_full} > CAPACITY) begin
                            next_state = ERR;
                        end else if (len_full == 32'd0) begin
                            next_state = CSUM;
                        end else begin
                            next_state = DATA;
                        end
                    end
                end
                DATA: begin
                    if (take && data_last) begin
                        next_state = CSUM;
                    end
                end
                CSUM: begin
                    if (take) begin
                        next_state = (in_data == sum) ? DONE : ERR;
                    end
                end
                default: next_state = state;
            endcase
        end
    end

    // A failed load keeps the CPU held: the memory image cannot be trusted.
    always_comb begin
        in_ready = 1'b0;
        cpu_hold = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        case (state)
            LEN, DATA, CSUM: begin
                in_ready = 1'b1;
                cpu_hold = 1'b1;
            end
            DONE: done = 1'b1;
            ERR: begin
                err      = 1'b1;
                cpu_hold = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            len_q   <= '0;
            sum     <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= 1'b0;
            if (load_start) begin
                cnt   <= '0;
                len_q <= '0;
                sum   <= '0;
            end else if (take) begin
                case (state)
                    LEN: begin
                        len_q[{cnt[1:0], 3'b000} +: 8] <= in_data;
                        cnt <= len_last ? '0 : cnt + CW'(1);
                    end
                    DATA: begin
                        wr_en   <= 1'b1;
                        wr_addr <= cnt[ADDR_WIDTH-1:0];
                        wr_data <= in_data;
                        cnt     <= cnt + CW'(1);
                        sum     <= sum + in_data;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
